// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the host-side SPI initiator and future SPI blocks.
//   - transfer mode encodings
//   - frame geometry (header and data period counts)
//   - FSM state encoding
//   - frame_bit(): the mosi value carried in a given frame bit slot
package spi_ctrl_pkg;

  localparam logic [1:0] MODE_RD     = 2'b00;
  localparam logic [1:0] MODE_RD_INC = 2'b01;
  localparam logic [1:0] MODE_WR     = 2'b10;

  localparam int HDR_BITS   = 7;
  localparam int DATA_BITS  = 10;
  localparam int FRAME_BITS = HDR_BITS + DATA_BITS;

  // Bit-slot indices used by the frame counter (0..FRAME_BITS-1).
  localparam logic [4:0] LAST_BIT     = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FIRST_DATA   = 5'(HDR_BITS);
  localparam logic [4:0] WR_END       = 5'(HDR_BITS + 8);
  // Read data occupies data periods 2..9; the first two periods give the
  // target time to fetch the addressed byte.
  localparam logic [4:0] RD_FIRST_BIT = 5'(HDR_BITS + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HDR   = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Any mode with bit 1 set is a write (10 and 11 behave identically).
  function automatic logic is_write(input logic [1:0] mode);
    return mode[1];
  endfunction

  // mosi value for frame slot idx: header {addr, mode} LSB-first, then
  // wdata LSB-first for writes, zeros everywhere else.
  function automatic logic frame_bit(input logic [4:0] idx,
                                     input logic [1:0] mode,
                                     input logic [4:0] addr,
                                     input logic [7:0] wdata);
    logic [6:0] hdr;
    logic [2:0] hdr_sel;
    logic [2:0] dat_sel;
    logic       bit_val;
    hdr     = {addr, mode};
    hdr_sel = idx[2:0];
    dat_sel = 3'(idx - FIRST_DATA);
    bit_val = 1'b0;
    if (idx < FIRST_DATA) begin
      bit_val = hdr[hdr_sel];
    end else if (is_write(mode) && (idx < WR_END)) begin
      bit_val = wdata[dat_sel];
    end
    return bit_val;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// SCLK generator. An 8-bit down-counter reloads with div-1 and toggles sclk
// on terminal count. rise_en / fall_en are single-cycle pulses asserted in
// the clk cycle at whose end sclk goes high / low, so logic using them
// updates on the same clk edge as sclk itself.
// Ports:
//   clk, rst      system clock, async active-low reset
//   en            run the divider; when low sclk is forced low and the
//                 counter is preloaded so the first rise comes div cycles
//                 after en rises
//   div           half-period in clk cycles (1..255)
//   sclk          SPI clock level, idle low
//   rise_en       pulse: sclk rises at the end of this cycle
//   fall_en       pulse: sclk falls at the end of this cycle
module spi_clk_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] div,
  output logic       sclk,
  output logic       rise_en,
  output logic       fall_en
);

  logic [7:0] cnt;
  logic       tc;

  assign tc      = (cnt == 8'd0);
  assign rise_en = en & tc & ~sclk;
  assign fall_en = en & tc & sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 8'd0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= div - 8'd1;
      sclk <= 1'b0;
    end else if (tc) begin
      cnt  <= div - 8'd1;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI initiator for the 32x8 SPI register/RAM target.
// One accepted start produces one cs_n-framed transaction of 17 SCLK
// periods: a 7-bit header {addr, mode} LSB-first followed by 10 data
// periods. Read data is returned on rdata with a one-cycle done pulse.
// Ports:
//   clk, rst          system clock, async active-low reset
//   start             request pulse, accepted only while busy=0
//   mode[1:0]         00 read, 01 read with target post-increment, 1x write
//   addr[4:0]         target address
//   wdata[7:0]        write data
//   busy              transaction (including inter-frame gap) in progress
//   done              one-cycle pulse at frame end
//   rdata[7:0]        last read result, updated only at done of a read
//   sclk, cs_n, mosi  SPI outputs (sclk idle low, cs_n active low)
//   miso              SPI input, sampled in the cycle sclk rises
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, cs_n high
// ST_SETUP | cs_n low, first header bit on mosi, waiting for first rise
// ST_HDR   | shifting out header bits 0..6
// ST_DATA  | data periods 0..9: write data out or read data in
// ST_GAP   | cs_n high for two SCLK periods before the next frame
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_L    = 8'(DIV);
  // GAP lasts 4*DIV cycles; counter runs 4*DIV-1 down to 0.
  localparam logic [9:0] GAP_LOAD = 10'(4 * DIV - 1);

  spi_state_e state;
  logic [1:0] mode_q;
  logic [4:0] addr_q;
  logic [7:0] wdata_q;
  logic [4:0] bit_cnt;
  logic [4:0] bit_nxt;
  logic [7:0] shift_q;
  logic [9:0] gap_cnt;
  logic       div_en;
  logic       rise_en;
  logic       fall_en;

  assign div_en  = (state == ST_SETUP) || (state == ST_HDR) || (state == ST_DATA);
  assign bit_nxt = bit_cnt + 5'd1;

  spi_clk_div u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .en      (div_en),
    .div     (DIV_L),
    .sclk    (sclk),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_RD;
      addr_q  <= 5'd0;
      wdata_q <= 8'd0;
      bit_cnt <= 5'd0;
      shift_q <= 8'd0;
      gap_cnt <= 10'd0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            addr_q  <= addr;
            wdata_q <= wdata;
            bit_cnt <= 5'd0;
            shift_q <= 8'd0;
            cs_n    <= 1'b0;
            mosi    <= mode[0];
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (rise_en) begin
            state <= ST_HDR;
          end
        end

        ST_HDR, ST_DATA: begin
          // Rise and fall pulses are mutually exclusive (they depend on
          // the current sclk level), so sampling and shifting never clash.
          if (rise_en && (state == ST_DATA) && (bit_cnt >= RD_FIRST_BIT)) begin
            shift_q <= {miso, shift_q[7:1]};
          end
          if (fall_en) begin
            if (bit_cnt == LAST_BIT) begin
              cs_n    <= 1'b1;
              mosi    <= 1'b0;
              done    <= 1'b1;
              bit_cnt <= 5'd0;
              gap_cnt <= GAP_LOAD;
              if (!is_write(mode_q)) begin
                rdata <= shift_q;
              end
              state <= ST_GAP;
            end else begin
              bit_cnt <= bit_nxt;
              mosi    <= frame_bit(bit_nxt, mode_q, addr_q, wdata_q);
              if (bit_nxt == FIRST_DATA) begin
                state <= ST_DATA;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 10'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 10'd1;
          end
        end

        default: begin
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: DIV=2 instance with a behavioural
// SPI target, plus DIV=1 and DIV=255 instances with miso tied high.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] start_a = 3'b000;
  logic [1:0] mode = 2'b00;
  logic [4:0] addr = 5'd0;
  logic [7:0] wdata = 8'd0;
  logic [2:0] busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic [7:0] rdata_a [3];
  logic       miso0 = 1'b0;

  int divs [3] = '{2, 1, 255};
  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_ctrl #(.DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .mode(mode), .addr(addr), .wdata(wdata),
    .busy(busy_a[0]), .done(done_a[0]), .rdata(rdata_a[0]),
    .sclk(sclk_a[0]), .cs_n(cs_a[0]), .mosi(mosi_a[0]), .miso(miso0));

  spi_master_ctrl #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .mode(mode), .addr(addr), .wdata(wdata),
    .busy(busy_a[1]), .done(done_a[1]), .rdata(rdata_a[1]),
    .sclk(sclk_a[1]), .cs_n(cs_a[1]), .mosi(mosi_a[1]), .miso(1'b1));

  spi_master_ctrl #(.DIV(255)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .mode(mode), .addr(addr), .wdata(wdata),
    .busy(busy_a[2]), .done(done_a[2]), .rdata(rdata_a[2]),
    .sclk(sclk_a[2]), .cs_n(cs_a[2]), .mosi(mosi_a[2]), .miso(1'b1));

  // Behavioural SPI target on instance 0: samples mosi on sclk rise,
  // drives miso after sclk fall, writes memory / advances its increment
  // pointer only for complete frames.
  logic [7:0] mem [32];
  logic       t_sclk_p = 1'b0;
  logic       t_cs_p = 1'b1;
  int         rc = 0;
  logic [6:0] t_hdr = 7'd0;
  logic [7:0] t_wd = 8'd0;
  logic [4:0] t_eff = 5'd0;
  logic [4:0] t_ptr = 5'd0;
  logic       t_inc = 1'b0;

  always @(negedge clk) begin
    if (!cs_a[0] && t_cs_p) begin
      rc = 0; t_hdr = 7'd0; t_wd = 8'd0;
    end
    if (!cs_a[0] && sclk_a[0] && !t_sclk_p) begin
      if (rc < 7) t_hdr[rc] = mosi_a[0];
      else if (rc < 15) t_wd[rc-7] = mosi_a[0];
      rc = rc + 1;
      if (rc == 7) t_eff = (t_hdr[1:0] == 2'b01 && t_inc) ? t_ptr : t_hdr[6:2];
    end
    if (!cs_a[0] && !sclk_a[0] && t_sclk_p) begin
      if (rc >= 9 && rc <= 16 && !t_hdr[1]) miso0 = mem[t_eff][rc-9];
      else miso0 = 1'b0;
    end
    if (cs_a[0] && !t_cs_p) begin
      if (rc == 17) begin
        if (t_hdr[1]) mem[t_hdr[6:2]] = t_wd;
        if (t_hdr[1:0] == 2'b01) begin t_ptr = t_eff + 5'd1; t_inc = 1'b1; end
        else t_inc = 1'b0;
      end else begin
        t_inc = 1'b0;
      end
      miso0 = 1'b0;
    end
    t_sclk_p = sclk_a[0];
    t_cs_p   = cs_a[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame observations, relative to the start cycle (rel 0).
  int          t0, rcnt, first_rise, last_rise, sp_min, sp_max;
  int          cs_fall_rel, cs_fall_cnt, cs_low, done_cnt, done_rel, busy_fall_rel;
  logic [16:0] bits;

  task automatic run_frame(input int u, input logic [1:0] m, input logic [4:0] a,
                           input logic [7:0] w, input int xs_rel, input int rst_rel,
                           input bit hold, input bit cont);
    int   rel, lim;
    logic sp, cp, tmo;
    lim = 40 * divs[u] + 20;
    rcnt = 0; first_rise = -1; last_rise = -1; sp_min = 1 << 30; sp_max = 0;
    cs_fall_rel = -1; cs_fall_cnt = 0; cs_low = 0; done_cnt = 0; done_rel = -1;
    busy_fall_rel = -1; bits = 17'd0;
    if (!cont) @(negedge clk);
    mode = m; addr = a; wdata = w; start_a[u] = 1'b1; t0 = cyc;
    sp = sclk_a[u]; cp = cs_a[u]; tmo = 1'b1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      rel = cyc - t0;
      start_a[u] = hold || (rel == xs_rel);
      if (rel == rst_rel) begin
        rst = 1'b0;
        #1;
        chk("rst_cs_n", 32'(cs_a[u]), 32'd1);
        chk("rst_sclk", 32'(sclk_a[u]), 32'd0);
        chk("rst_busy", 32'(busy_a[u]), 32'd0);
        chk("rst_done", 32'(done_a[u]), 32'd0);
        chk("rst_mosi", 32'(mosi_a[u]), 32'd0);
        chk("rst_rdata", 32'(rdata_a[u]), 32'h00);
        tmo = 1'b0;
        break;
      end
      if (sclk_a[u] && !sp) begin
        if (rcnt < 17) bits[rcnt] = mosi_a[u];
        if (rcnt == 0) first_rise = rel;
        else begin
          if (rel - last_rise < sp_min) sp_min = rel - last_rise;
          if (rel - last_rise > sp_max) sp_max = rel - last_rise;
        end
        last_rise = rel;
        rcnt = rcnt + 1;
      end
      if (!cs_a[u] && cp) begin cs_fall_rel = rel; cs_fall_cnt = cs_fall_cnt + 1; end
      if (!cs_a[u]) cs_low = cs_low + 1;
      if (done_a[u]) begin done_cnt = done_cnt + 1; done_rel = rel; end
      sp = sclk_a[u]; cp = cs_a[u];
      if (!busy_a[u]) begin busy_fall_rel = rel; tmo = 1'b0; break; end
    end
    chk("frame_timeout", 32'(tmo), 32'd0);
  endtask

  task automatic chk_timing(input string tag, input int d);
    chk({tag, "_cs_fall"}, cs_fall_rel, 1);
    chk({tag, "_first_rise"}, first_rise, 1 + d);
    chk({tag, "_last_rise"}, last_rise, 1 + 33 * d);
    chk({tag, "_rises"}, rcnt, 17);
    chk({tag, "_done_rel"}, done_rel, 1 + 34 * d);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_fall"}, busy_fall_rel, 1 + 38 * d);
    chk({tag, "_cs_low"}, cs_low, 34 * d);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
    mem[4] = 8'h3C;
    mem[5] = 8'h96;
    repeat (3) @(negedge clk);
    chk("reset_sclk", 32'(sclk_a[0]), 32'd0);
    chk("reset_cs_n", 32'(cs_a[0]), 32'd1);
    chk("reset_mosi", 32'(mosi_a[0]), 32'd0);
    chk("reset_busy", 32'(busy_a[0]), 32'd0);
    chk("reset_done", 32'(done_a[0]), 32'd0);
    chk("reset_rdata", 32'(rdata_a[0]), 32'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5 to 0x13.
    run_frame(0, 2'b10, 5'h13, 8'hA5, -1, -1, 1'b0, 1'b0);
    chk_timing("wr", 2);
    chk("wr_mosi_bits", 32'(bits), 32'h052CE);
    chk("wr_rdata_kept", 32'(rdata_a[0]), 32'h00);
    chk("wr_target_mem", 32'(mem[5'h13]), 32'hA5);

    // Plain read of 0x04.
    run_frame(0, 2'b00, 5'h04, 8'hFF, -1, -1, 1'b0, 1'b0);
    chk_timing("rd", 2);
    chk("rd_mosi_bits", 32'(bits), 32'h00010);
    chk("rd_rdata", 32'(rdata_a[0]), 32'h3C);

    // Read-increment with start held: second frame accepted exactly at rel 77.
    run_frame(0, 2'b01, 5'h04, 8'h00, -1, -1, 1'b1, 1'b0);
    chk("inc1_rdata", 32'(rdata_a[0]), 32'h3C);
    chk("inc1_busy_fall", busy_fall_rel, 77);
    chk("inc1_cs_falls", cs_fall_cnt, 1);
    chk("inc1_mosi_bits", 32'(bits), 32'h00011);
    run_frame(0, 2'b01, 5'h04, 8'h00, -1, -1, 1'b0, 1'b1);
    chk("inc2_cs_fall", cs_fall_rel, 1);
    chk("inc2_done_rel", done_rel, 69);
    chk("inc2_rdata", 32'(rdata_a[0]), 32'h96);

    // start pulse at cycle 10 of a write frame must be ignored.
    run_frame(0, 2'b10, 5'h0A, 8'h5A, 10, -1, 1'b0, 1'b0);
    chk("busy_start_cs_falls", cs_fall_cnt, 1);
    chk("busy_start_cs_low", cs_low, 68);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_mem", 32'(mem[5'h0A]), 32'h5A);
    chk("busy_start_rdata_kept", 32'(rdata_a[0]), 32'h96);
    repeat (5) @(negedge clk);
    chk("busy_start_no_requeue", 32'({busy_a[0], cs_a[0]}), 32'b01);

    // Reset in the middle of a read, then a clean write.
    run_frame(0, 2'b00, 5'h05, 8'h00, -1, 30, 1'b0, 1'b0);
    chk("rst_no_done", done_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, 2'b11, 5'h1F, 8'h81, -1, -1, 1'b0, 1'b0);
    chk_timing("post_rst", 2);
    chk("post_rst_mosi_bits", 32'(bits), 32'h040FF);
    chk("post_rst_mem", 32'(mem[5'h1F]), 32'h81);

    // Divider extremes.
    run_frame(1, 2'b00, 5'h02, 8'h00, -1, -1, 1'b0, 1'b0);
    chk_timing("div1", 1);
    chk("div1_sp_min", sp_min, 2);
    chk("div1_sp_max", sp_max, 2);
    chk("div1_rdata", 32'(rdata_a[1]), 32'hFF);
    run_frame(2, 2'b00, 5'h02, 8'h00, -1, -1, 1'b0, 1'b0);
    chk_timing("div255", 255);
    chk("div255_done", done_rel, 8671);
    chk("div255_sp_min", sp_min, 510);
    chk("div255_sp_max", sp_max, 510);
    chk("div255_rdata", 32'(rdata_a[2]), 32'hFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side SPI initiator for the on-chip 32×8 register/RAM SPI target. It converts a single-cycle host request (mode, address, write data) into one chip-select framed SPI transaction and returns read data with a done pulse. It runs entirely in the system clock domain, generating SCLK from a programmable divider. It sits between the host bus logic and the SPI pins.

## Interface
- DIV, default 2: SCLK half-period in clk cycles; legal range 1..255; SCLK frequency = clk / (2·DIV).
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- mode  input  2  00 read, 01 read with target address post-increment, 10/11 write.
- addr  input  5  target address.
- wdata  input  8  write data (ignored for reads).
- busy  output  1  high from the cycle after acceptance through the end of the inter-frame gap.
- done  output  1  one-cycle pulse at frame end.
- rdata  output  8  read data; valid from done, held until the next read completes.
- sclk  output  1  SPI clock, idle low.
- cs_n  output  1  chip select, active low.
- mosi  output  1  serial data to target.
- miso  input  1  serial data from target.

## Operation
- FSM states: IDLE, SETUP, HDR, DATA, GAP.
  - IDLE→SETUP on start: latch mode/addr/wdata, cs_n←0, mosi←mode[0].
  - SETUP→HDR after DIV cycles, at the first sclk rise.
  - HDR→DATA after 7 rises.
  - DATA→GAP after 10 rises, on the following fall: cs_n←1, done=1.
  - GAP→IDLE after 4·DIV cycles (two SCLK periods, cs_n high).
- Header: 7 bits, LSB-first: mode[0], mode[1], addr[0]..addr[4].
- Data phase: 10 SCLK periods.
  - Write: wdata[0]..wdata[7] on data periods 0..7; mosi=0 on periods 8..9.
  - Read: mosi=0 throughout. miso is sampled on the rises of data periods 2..9 and shifted LSB-first: shift right, miso enters bit 7. rdata updates only at done.
- mosi changes only on sclk falling edges, or on the cs_n falling edge for the first bit. The target samples on the rising edge.
- Frame bit counter is 5 bits wide and counts 0..16. The divider counter is 8 bits wide. All wraps are explicit; there is no overflow path.
- A start while busy=1 is ignored, with no queuing. A start held high in IDLE launches back-to-back frames, each separated by the full GAP.
- The mode 01 address increment is performed by the target; this block does not modify addr.

## Timing
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=8'h00, FSM=IDLE.
- Reset asserted mid-frame immediately returns all outputs to their reset values. The transaction is lost and no done is produced.
- Relative to the start cycle (cycle 0):
  - cs_n low at cycle 1.
  - sclk rise k (k=0..16) at cycle 1+DIV+2·DIV·k.
  - Last sclk fall, cs_n high and done at cycle 1+34·DIV.
  - busy low at cycle 1+38·DIV.
  - Next start accepted at cycle 1+38·DIV.
- For DIV=2: cs_n falls at cycle 1, first rise at cycle 3, last rise at cycle 67, done at cycle 69, busy falls at cycle 77.
- miso setup/hold: sampled in the clk cycle in which sclk rises (registered edge enable).

## Structure
- Package spi_ctrl_pkg holds:
  - Mode constants MODE_RD=2'b00, MODE_RD_INC=2'b01, MODE_WR=2'b10.
  - HDR_BITS=7 and DATA_BITS=10.
  - The FSM state encoding, shared with future SPI blocks.
- One sub-module, spi_clk_div: an 8-bit counter producing single-cycle rise_en/fall_en pulses and the sclk level while enabled. It is held in reset (sclk=0) outside SETUP/HDR/DATA.

## Test plan
- Write, DIV=2, mode=10, addr=5'h13, wdata=8'hA5 → mosi over the 17 rises = 0,1,1,1,0,0,1, then 1,0,1,0,0,1,0,1,0,0; done at cycle 69; rdata unchanged.
- Read, mode=00, addr=5'h04, miso model returns 8'h3C LSB-first on data periods 2..9 → rdata=8'h3C at done; mosi=0 throughout the data phase.
- Read-increment, mode=01, with a target model → two consecutive frames return mem[4] then mem[5], and start is not accepted before busy falls at cycle 77.
- start asserted at cycle 10 of a frame → ignored; exactly one cs_n low window of 68 cycles (DIV=2).
- rst low at cycle 30 of a frame → same cycle: cs_n=1, sclk=0, busy=0, no done; a new start after release produces a clean frame.
- DIV=1 and DIV=255 → edge spacing 2 and 510 clk cycles; 17 rises per frame; done at cycles 35 and 8671.
